regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
Read-side companion to the two-read-port register file. On a start pulse it sweeps a programmable register index range, drives the regfile read selects (`src_a`/`src_b`), and captures `reg_a`/`reg_b`. The captured contents go out as an index-tagged valid/ready stream. Used for state dump, checkpoint and debug readout, alongside normal regfile traffic.

Parameters:
- `DATA_W`, 32, regfile word width
- `IDX_W`, 5, register index width
- `NUM_REGS`, 32, number of registers; indices `0..NUM_REGS-1`

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE
- `first`  in  `IDX_W`  first index to dump; sampled with `start`
- `last`  in  `IDX_W`  last index to dump, inclusive; sampled with `start`
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` pulses
- `done`  out  1  one-cycle pulse when the dump completes
- `src_a`  out  `IDX_W`  regfile read select, port A
- `src_b`  out  `IDX_W`  regfile read select, port B
- `reg_a`  in  `DATA_W`  regfile read data, port A; combinational from `src_a`
- `reg_b`  in  `DATA_W`  regfile read data, port B; combinational from `src_b`
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  downstream accepts the word
- `out_idx`  out  `IDX_W`  register index of the stream word
- `out_data`  out  `DATA_W`  register contents
- `out_last`  out  1  marks the word for index `last`

Behaviour:
- Reset (async, `rst_n`=0): state IDLE. `busy`, `done`, `out_valid`, `out_last` = 0. `src_a`, `src_b`, `out_idx`, `out_data` = 0. Pointer, buffer and count cleared. Applies immediately, including mid-dump. In-flight words are discarded and no `done` is issued.
- States: IDLE, FETCH, DRAIN, FIN.
- IDLE:
  - `start`=1 with `first`<=`last` and `last`<`NUM_REGS`: latch the range, set `ptr`=`first`, go to FETCH.
  - `start` with `first`>`last` or `last`>=`NUM_REGS`: go to FIN with no stream output.
- `start` outside IDLE is ignored.
- Read selects: `src_a`=`ptr`, `src_b`=`ptr+1` (truncated to `IDX_W`) while in FETCH. Both hold 0 in all other states.
- Buffer: 2-entry FIFO of {idx, data, last}, `count` 0..2. The head drives `out_*`. `out_valid` = (`count` != 0).
- Pop: `out_valid` && `out_ready` at the clock edge. `out_*` must stay stable while `out_valid`=1 and `out_ready`=0.
- Capture condition in FETCH: `count`==0, or (`count`==1 and pop this cycle).
  - On capture, push {`ptr`, `reg_a`, `ptr`==`last`}.
  - If `ptr`<`last`, also push {`ptr+1`, `reg_b`, `ptr+1`==`last`} behind it.
  - Advance `ptr` by the number of entries pushed.
- Data is the regfile value present in the capture cycle. A regfile write landing in the same cycle follows the regfile's own read-during-write behaviour. The dumper adds no bypass.
- FETCH -> DRAIN when the entry with `last`=1 has been pushed. DRAIN -> FIN when `count`==0.
- FIN: `done`=1 for exactly one cycle, then IDLE. `busy` drops in the FIN cycle.
- Throughput: at most one word per cycle at the output. First word appears 1 cycle after the `start` edge (captured in the first FETCH cycle, visible the next). Steady state with `out_ready`=1: one word per cycle, no bubbles.
- Backpressure: capture stalls (`ptr` held) while the capture condition is false. No word is lost or duplicated.
- Single-register range (`first`==`last`): exactly one word, `out_last`=1. Port B is unused.
- Range reaching `NUM_REGS-1`: `ptr+1` wraps on `src_b`, but the wrapped port-B word is never pushed.

Optional Feature:
- `REGFILE_DUMP_CSUM_EN`
  - Defined: adds output `csum [DATA_W-1:0]`. XOR of all popped `out_data` words in the current dump. Cleared on accepted `start` and on reset. Valid and stable in the `done` cycle, held until the next accepted `start`. An empty range gives `csum`=0.
  - Undefined: no `csum` port, no accumulator logic.

Test Plan:
- After reset, write reg *i* = *i* for 1..31. Then `start` with `first`=1, `last`=31, `out_ready`=1 -> 31 words, idx/data 1..31 in order, one per cycle. `out_last` only on idx 31. `done` pulses once. With CSUM, `csum`=0x00000000 (XOR of 1..31).
- Same regfile contents, `first`=4, `last`=4 -> single word {4, 0x4, last=1}, then `done`.
- `first`=10, `last`=15, `out_ready` toggled 1,0,0,1,... -> words 10..15 exactly once each, stable while stalled. No `done` before the word for idx 15 is popped.
- `first`=20, `last`=3 -> no `out_valid`, `done` pulse 1 cycle after `start`, `busy` never high.
- Assert `rst_n`=0 after the third word of a 1..31 dump -> all outputs 0 immediately, no `done`. A new `start` (`first`=1, `last`=2) then yields {1,0x1}, {2,0x2}.
- `start` pulsed again during a busy dump -> ignored; the original dump completes unchanged.

Source files
------------

// File: rtl/regfile_dump.sv
// Register-file dump engine: sweeps an index range over two read ports and streams index-tagged words.
// Optional build macro REGFILE_DUMP_CSUM_EN adds an XOR checksum output of all popped words.
module regfile_dump #(
   parameter int DATA_W   = 32,
   parameter int IDX_W    = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [IDX_W-1:0]  first,
   input  logic [IDX_W-1:0]  last,
   output logic              busy,
   output logic              done,
   output logic [IDX_W-1:0]  src_a,
   output logic [IDX_W-1:0]  src_b,
   input  logic [DATA_W-1:0] reg_a,
   input  logic [DATA_W-1:0] reg_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
`ifdef REGFILE_DUMP_CSUM_EN
   ,
   output logic [DATA_W-1:0] csum
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_TWO = IDX_W'(2);

   logic [1:0]        state, state_nx;
   logic [IDX_W-1:0]  ptr, ptr_nx;
   logic [IDX_W-1:0]  last_q, last_nx;
   logic [1:0]        count, count_nx;

   logic [IDX_W-1:0]  hd_idx, hd_idx_nx;
   logic [DATA_W-1:0] hd_data, hd_data_nx;
   logic              hd_last, hd_last_nx;
   logic [IDX_W-1:0]  tl_idx, tl_idx_nx;
   logic [DATA_W-1:0] tl_data, tl_data_nx;
   logic              tl_last, tl_last_nx;

   logic              in_fetch;
   logic              pop;
   logic              cap;
   logic              pair;
   logic              pushed_last;
   logic              range_ok;
   logic [IDX_W-1:0]  ptr_inc;

   assign in_fetch = (state == S_FETCH);
   assign ptr_inc  = ptr + IDX_ONE;
   assign pop      = (count != 2'd0) && out_ready;
   assign pair     = (ptr < last_q);
   assign cap      = in_fetch && ((count == 2'd0) || ((count == 2'd1) && pop));
   assign pushed_last = (ptr == last_q) || (pair && (ptr_inc == last_q));
   assign range_ok = (first <= last) && ((IDX_W+1)'(last) < (IDX_W+1)'(NUM_REGS));

   assign busy      = (state == S_FETCH) || (state == S_DRAIN);
   assign done      = (state == S_FIN);
   assign src_a     = in_fetch ? ptr     : '0;
   assign src_b     = in_fetch ? ptr_inc : '0;
   assign out_valid = (count != 2'd0);
   assign out_idx   = hd_idx;
   assign out_data  = hd_data;
   assign out_last  = hd_last;

   // A pop and a capture in the same cycle only happens from count==1, so the
   // capture simply overwrites the head slot that the pop just vacated.
   always_comb begin
      hd_idx_nx  = hd_idx;
      hd_data_nx = hd_data;
      hd_last_nx = hd_last;
      tl_idx_nx  = tl_idx;
      tl_data_nx = tl_data;
      tl_last_nx = tl_last;
      count_nx   = count;
      ptr_nx     = ptr;
      last_nx    = last_q;
      state_nx   = state;

      if (pop) begin
         count_nx = count - 2'd1;
         if (count == 2'd2) begin
            hd_idx_nx  = tl_idx;
            hd_data_nx = tl_data;
            hd_last_nx = tl_last;
         end
      end

      if (cap) begin
         hd_idx_nx  = ptr;
         hd_data_nx = reg_a;
         hd_last_nx = (ptr == last_q);
         if (pair) begin
            tl_idx_nx  = ptr_inc;
            tl_data_nx = reg_b;
            tl_last_nx = (ptr_inc == last_q);
            count_nx   = 2'd2;
            ptr_nx     = ptr + IDX_TWO;
         end else begin
            count_nx   = 2'd1;
            ptr_nx     = ptr_inc;
         end
      end

      case (state)
         S_IDLE: begin
            if (start) begin
               if (range_ok) begin
                  last_nx  = last;
                  ptr_nx   = first;
                  state_nx = S_FETCH;
               end else begin
                  state_nx = S_FIN;
               end
            end
         end
         S_FETCH: begin
            if (cap && pushed_last) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (count == 2'd0) state_nx = S_FIN;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ptr     <= '0;
         last_q  <= '0;
         count   <= '0;
         hd_idx  <= '0;
         hd_data <= '0;
         hd_last <= 1'b0;
         tl_idx  <= '0;
         tl_data <= '0;
         tl_last <= 1'b0;
      end else begin
         state   <= state_nx;
         ptr     <= ptr_nx;
         last_q  <= last_nx;
         count   <= count_nx;
         hd_idx  <= hd_idx_nx;
         hd_data <= hd_data_nx;
         hd_last <= hd_last_nx;
         tl_idx  <= tl_idx_nx;
         tl_data <= tl_data_nx;
         tl_last <= tl_last_nx;
      end
   end

`ifdef REGFILE_DUMP_CSUM_EN
   logic [DATA_W-1:0] csum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= '0;
      end else if ((state == S_IDLE) && start) begin
         csum_q <= '0;
      end else if (pop) begin
         csum_q <= csum_q ^ hd_data;
      end
   end

   assign csum = csum_q;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: expected words queued at start, a monitor pops and compares.
// Checksum checks are compiled in when REGFILE_DUMP_CSUM_EN is defined.
module tb_regfile_dump;
   localparam int DW = 32;
   localparam int IW = 5;
   localparam int NR = 32;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [DW-1:0] data;
      logic          last;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [IW-1:0] first = '0;
   logic [IW-1:0] last = '0;
   logic          busy, done, out_valid, out_last;
   logic          out_ready = 1'b1;
   logic [IW-1:0] src_a, src_b, out_idx;
   logic [DW-1:0] reg_a, reg_b, out_data;
`ifdef REGFILE_DUMP_CSUM_EN
   logic [DW-1:0] csum;
   logic [DW-1:0] exp_csum = '0;
`endif

   logic [DW-1:0] rf [NR];
   assign reg_a = rf[src_a];
   assign reg_b = rf[src_b];

   regfile_dump #(.DATA_W(DW), .IDX_W(IW), .NUM_REGS(NR)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .first(first), .last(last),
      .busy(busy), .done(done), .src_a(src_a), .src_b(src_b),
      .reg_a(reg_a), .reg_b(reg_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_data(out_data), .out_last(out_last)
`ifdef REGFILE_DUMP_CSUM_EN
      , .csum(csum)
`endif
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   ent_t exp_q[$];
   int   done_cnt = 0;
   int   pop_cnt = 0;
   int   cyc = 0;
   int   first_pop_cyc = -1;
   int   last_pop_cyc = -1;
   bit   busy_seen = 1'b0;
   int   rmode = 0;
   int   rphase = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a dump of a legal range is every index in order, tagged last on the final one.
   task automatic push_expected(input int f, input int l);
`ifdef REGFILE_DUMP_CSUM_EN
      exp_csum = '0;
`endif
      if (f <= l && l < NR) begin
         for (int i = f; i <= l; i++) begin
            exp_q.push_back('{idx: IW'(i), data: rf[i], last: (i == l)});
`ifdef REGFILE_DUMP_CSUM_EN
            exp_csum = exp_csum ^ rf[i];
`endif
         end
      end
   endtask

   // Ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         rphase++;
         case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = ((rphase % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor
   initial begin
      bit              prev_stall;
      logic [IW+DW:0]  prev_word;
      ent_t            e;
      prev_stall = 1'b0;
      prev_word  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_stall = 1'b0;
            continue;
         end
         if (busy) busy_seen = 1'b1;
         if (prev_stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_word", 64'({out_idx, out_data, out_last}), 64'(prev_word));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got idx %0d data 0x%0h, expected no word", out_idx, out_data);
            end else begin
               e = exp_q.pop_front();
               chk("word", 64'({out_idx, out_data, out_last}), 64'(e));
            end
            pop_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_word  = {out_idx, out_data, out_last};
         if (done) begin
            done_cnt++;
            chk("done_after_all_words", 64'(exp_q.size()), 64'd0);
            chk("done_busy_low", 64'(busy), 64'd0);
`ifdef REGFILE_DUMP_CSUM_EN
            chk("csum", 64'(csum), 64'(exp_csum));
`endif
         end
      end
   end

   task automatic run_dump(input int f, input int l, input bit inject);
      int d0;
      bit got;
      @(posedge clk);
      #2;
      d0 = done_cnt;
      first_pop_cyc = -1;
      busy_seen = 1'b0;
      push_expected(f, l);
      first = IW'(f);
      last  = IW'(l);
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 500 && !got; k++) begin
         @(posedge clk);
         #2;
         if (inject && k == 4) begin
            start = 1'b1;
            first = IW'($urandom_range(0, 31));
            last  = IW'($urandom_range(0, 31));
         end else begin
            start = 1'b0;
         end
         if (done_cnt != d0) got = 1'b1;
      end
      start = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done, expected done for range %0d..%0d", f, l);
      end
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      chk("done_once", 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin
      int d0, pc0, f, l;
      for (int i = 0; i < NR; i++) rf[i] = DW'(i);

      #1;
      chk("rst_ctrl", 64'({busy, done, out_valid, out_last}), 64'd0);
      chk("rst_data", 64'({src_a, src_b, out_idx, out_data}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // full sweep, always ready: one word per cycle
      rmode = 0;
      run_dump(1, 31, 1'b0);
      chk("no_bubbles", 64'(last_pop_cyc - first_pop_cyc), 64'd30);

      // single register
      run_dump(4, 4, 1'b0);

      // backpressure pattern
      rmode = 1;
      run_dump(10, 15, 1'b0);
      rmode = 0;

      // empty range: done one cycle after start, no busy, no words
      @(posedge clk);
      #2;
      d0 = done_cnt;
      busy_seen = 1'b0;
      push_expected(20, 3);
      first = IW'(20);
      last  = IW'(3);
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      chk("empty_done", 64'(done), 64'd1);
      chk("empty_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #2;
      chk("empty_done_pulse", 64'(done), 64'd0);
      repeat (2) @(posedge clk);
      chk("empty_busy_never", 64'(busy_seen), 64'd0);
      chk("empty_done_once", 64'(done_cnt - d0), 64'd1);

      // reset mid-dump after the third word
      @(posedge clk);
      #2;
      d0 = done_cnt;
      pc0 = pop_cnt;
      push_expected(1, 31);
      first = IW'(1);
      last  = IW'(31);
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
      for (int k = 0; k < 100 && (pop_cnt - pc0) < 3; k++) @(posedge clk);
      if ((pop_cnt - pc0) < 3) begin
         checks++;
         errors++;
         $display("FAIL reset_wait: got %0d words, expected 3", pop_cnt - pc0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", 64'({busy, done, out_valid, out_last}), 64'd0);
      chk("midrst_data", 64'({src_a, src_b, out_idx, out_data}), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
      run_dump(1, 2, 1'b0);

      // start while busy is ignored
      rmode = 1;
      run_dump(5, 25, 1'b1);
      rmode = 0;

      // random contents, ranges and backpressure, plus top-of-file boundary
      for (int i = 0; i < NR; i++) rf[i] = $urandom;
      rmode = 2;
      run_dump(28, 31, 1'b0);
      run_dump(31, 31, 1'b0);
      run_dump(0, 0, 1'b0);
      for (int t = 0; t < 10; t++) begin
         f = $urandom_range(0, 31);
         l = $urandom_range(0, 31);
         if (t % 3 != 2 && f > l) begin
            int tmp;
            tmp = f;
            f = l;
            l = tmp;
         end
         rmode = $urandom_range(0, 2);
         run_dump(f, l, (t % 4) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
